// File: rtl/decode_cycle_if.sv
// decode_cycle_if: D-stage inputs, writeback port, flush and E-stage outputs of the decode stage
//   master: drives InstrD/PCD/PCPlus4D, RegWriteW/RdW/ResultW, FlushE; receives all *E signals
//   slave : the decode stage itself
interface decode_cycle_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        FlushE;
  logic        RegWriteE;
  logic        ResultSrcE;
  logic        MemWriteE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );
  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage (register file, control decoder, immediate extender) and ID/EX register
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears register file and all E outputs
//   bus   : slave side of decode_cycle_if (D inputs, writeback port, FlushE, E outputs)
module decode_cycle (
  input logic           clk,
  input logic           rst_n,
  decode_cycle_if.slave bus
);
  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ex_t;
  logic [31:0] rf_q [32];
  ex_t         e_d, e_q;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2;
  logic        wr_en;
  logic        is_lw, is_sw, is_r, is_i, is_b;
  logic [2:0]  alu_fn;
  logic [31:0] imm_i, imm_s, imm_b;
  assign instr = bus.InstrD;
  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign wr_en = bus.RegWriteW && (bus.RdW != 5'd0);
  always_ff @(posedge clk) begin
    if (!rst_n)
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    else if (wr_en)
      rf_q[bus.RdW] <= bus.ResultW;
  end
  assign is_lw = op == 7'b0000011;
  assign is_sw = op == 7'b0100011;
  assign is_r  = op == 7'b0110011;
  assign is_i  = op == 7'b0010011;
  assign is_b  = op == 7'b1100011;
  // funct3 000 turns into sub only for R-type with funct7[5]; I-type never subtracts
  assign alu_fn = f3 == 3'b010 ? 3'b101 :
                  f3 == 3'b110 ? 3'b011 :
                  f3 == 3'b111 ? 3'b010 :
                  (is_r && instr[30] && f3 == 3'b000) ? 3'b001 : 3'b000;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  always_comb begin
    e_d            = '0;
    e_d.reg_write  = is_lw | is_r | is_i;
    e_d.result_src = is_lw;
    e_d.mem_write  = is_sw;
    e_d.branch     = is_b;
    e_d.alu_src    = is_lw | is_sw | is_i;
    e_d.alu_ctrl   = is_b ? 3'b001 : (is_r | is_i) ? alu_fn : 3'b000;
    e_d.imm        = (is_lw | is_i) ? imm_i : is_sw ? imm_s : is_b ? imm_b : 32'd0;
    // writeback in the same cycle is forwarded so the read never sees stale data
    e_d.rd1        = rs1 == 5'd0 ? 32'd0 : (wr_en && bus.RdW == rs1) ? bus.ResultW : rf_q[rs1];
    e_d.rd2        = rs2 == 5'd0 ? 32'd0 : (wr_en && bus.RdW == rs2) ? bus.ResultW : rf_q[rs2];
    e_d.rs1        = rs1;
    e_d.rs2        = rs2;
    e_d.rd         = instr[11:7];
    e_d.pc         = bus.PCD;
    e_d.pc4        = bus.PCPlus4D;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushE)
      e_q <= '0;
    else
      e_q <= e_d;
  end
  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.ResultSrcE  = e_q.result_src;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.BranchE     = e_q.branch;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.ALUControlE = e_q.alu_ctrl;
  assign bus.RD1E        = e_q.rd1;
  assign bus.RD2E        = e_q.rd2;
  assign bus.ImmExtE     = e_q.imm;
  assign bus.Rs1E        = e_q.rs1;
  assign bus.Rs2E        = e_q.rs2;
  assign bus.RdE         = e_q.rd;
  assign bus.PCE         = e_q.pc;
  assign bus.PCPlus4E    = e_q.pc4;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed scoreboard bench for decode_cycle
module tb_decode_cycle;
  typedef struct packed {
    logic        rw;
    logic        rs;
    logic        mw;
    logic        br;
    logic        as;
    logic [2:0]  alu;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc = 32'h0000_1000;
  exp_t        sb[$];
  decode_cycle_if bus ();
  decode_cycle dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  function automatic exp_t ex(logic rw, logic rs, logic mw, logic br, logic as, logic [2:0] alu,
                              logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
    exp_t x;
    x = '0;
    x.rw = rw; x.rs = rs; x.mw = mw; x.br = br; x.as = as; x.alu = alu;
    x.rd1 = rd1; x.rd2 = rd2; x.imm = imm; x.r1 = r1; x.r2 = r2; x.rd = rd;
    return x;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [31:0] instr, input logic rw, input logic [4:0] rdw,
                      input logic [31:0] res, input logic flush, input logic rstn, input exp_t x);
    exp_t e;
    bus.InstrD    = instr;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.RegWriteW = rw;
    bus.RdW       = rdw;
    bus.ResultW   = res;
    bus.FlushE    = flush;
    rst_n         = rstn;
    e = x;
    if (rstn && !flush) begin
      e.pc  = pc;
      e.pc4 = pc + 32'd4;
    end
    sb.push_back(e);
    pc = pc + 32'd4;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() == 1) else begin
      errors++;
      $error("FAIL %s_sb observed=%0d expected=1", tag, sb.size());
    end
    e = sb.pop_front();
    chk({tag, "_RegWriteE"},   {31'd0, bus.RegWriteE},   {31'd0, e.rw});
    chk({tag, "_ResultSrcE"},  {31'd0, bus.ResultSrcE},  {31'd0, e.rs});
    chk({tag, "_MemWriteE"},   {31'd0, bus.MemWriteE},   {31'd0, e.mw});
    chk({tag, "_BranchE"},     {31'd0, bus.BranchE},     {31'd0, e.br});
    chk({tag, "_ALUSrcE"},     {31'd0, bus.ALUSrcE},     {31'd0, e.as});
    chk({tag, "_ALUControlE"}, {29'd0, bus.ALUControlE}, {29'd0, e.alu});
    chk({tag, "_RD1E"},        bus.RD1E,                 e.rd1);
    chk({tag, "_RD2E"},        bus.RD2E,                 e.rd2);
    chk({tag, "_ImmExtE"},     bus.ImmExtE,              e.imm);
    chk({tag, "_Rs1E"},        {27'd0, bus.Rs1E},        {27'd0, e.r1});
    chk({tag, "_Rs2E"},        {27'd0, bus.Rs2E},        {27'd0, e.r2});
    chk({tag, "_RdE"},         {27'd0, bus.RdE},         {27'd0, e.rd});
    chk({tag, "_PCE"},         bus.PCE,                  e.pc);
    chk({tag, "_PCPlus4E"},    bus.PCPlus4E,             e.pc4);
  endtask
  initial begin
    exp_t z;
    z = '0;
    // reset with a write to x5 presented: ignored
    step("rst0", 32'h005282B3, 1'b1, 5'd5, 32'h0000DEAD, 1'b0, 1'b0, z);
    step("rst1", 32'h005282B3, 1'b1, 5'd5, 32'h0000DEAD, 1'b0, 1'b0, z);
    step("add_x5", 32'h005282B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5));
    // write x3 under an unknown-opcode nop
    step("wr_x3", 32'h00000000, 1'b1, 5'd3, 32'h00001234, 1'b0, 1'b1, z);
    step("rd_x3", 32'h00018233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'h00001234, 32'h0, 32'h0, 5'd3, 5'd0, 5'd4));
    step("byp_x3", 32'h00018233, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'hCAFEF00D, 32'h0, 32'h0, 5'd3, 5'd0, 5'd4));
    step("late_x3", 32'h00018233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'hCAFEF00D, 32'h0, 32'h0, 5'd3, 5'd0, 5'd4));
    step("x0_same", 32'h000000B3, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1));
    step("x0_late", 32'h000000B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1));
    // lw x6,-4(x2) while x2 is written with 0x55 in the same cycle
    step("lw", 32'hFFC12303, 1'b1, 5'd2, 32'h00000055, 1'b0, 1'b1,
         ex(1,1,0,0,1,3'b000, 32'h00000055, 32'h0, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd6));
    step("sw", 32'hFE312C23, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(0,0,1,0,1,3'b000, 32'h00000055, 32'hCAFEF00D, 32'hFFFFFFF8, 5'd2, 5'd3, 5'd24));
    step("sub", 32'h404182B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b001, 32'hCAFEF00D, 32'h0, 32'h0, 5'd3, 5'd4, 5'd5));
    step("addi_nosub", 32'hC0000093, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,1,3'b000, 32'h0, 32'h0, 32'hFFFFFC00, 5'd0, 5'd0, 5'd1));
    step("slti", 32'h0051A313, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,1,3'b101, 32'hCAFEF00D, 32'h0, 32'h00000005, 5'd3, 5'd5, 5'd6));
    step("or", 32'h0041E4B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b011, 32'hCAFEF00D, 32'h0, 32'h0, 5'd3, 5'd4, 5'd9));
    step("andi", 32'h0FF1F513, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,1,3'b010, 32'hCAFEF00D, 32'h0, 32'h000000FF, 5'd3, 5'd31, 5'd10));
    step("xor_add", 32'h4041C4B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'hCAFEF00D, 32'h0, 32'h0, 5'd3, 5'd4, 5'd9));
    step("bad_op", 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(0,0,0,0,0,3'b000, 32'h0, 32'h0, 32'h0, 5'd31, 5'd31, 5'd31));
    step("beq", 32'h00208463, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(0,0,0,1,0,3'b001, 32'h0, 32'h00000055, 32'h00000008, 5'd1, 5'd2, 5'd8));
    // flush still lets the x7 write through
    step("beq_flush", 32'h00208463, 1'b1, 5'd7, 32'h00000077, 1'b1, 1'b1, z);
    step("rd_x7", 32'h00038233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'h00000077, 32'h0, 32'h0, 5'd7, 5'd0, 5'd4));
    step("flush_rst", 32'h00208463, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, z);
    step("post_rst", 32'h00018233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
         ex(1,0,0,0,0,3'b000, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd4));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Decode stage and ID/EX pipeline register of the 5-stage RV32I pipeline.
- Sits at the read end of the register-file interface that the writeback stage drives (RegWriteW/RdW/ResultW).
- Contains the 32x32 register file (write on clock edge, combinational read with same-cycle write bypass), the main/ALU control decoder and the immediate extender.
- Registers everything into the E stage.

Parameters:
- None. Widths fixed: XLEN=32, 32 architectural registers.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- InstrD  input  32  instruction in D stage
- PCD  input  32  PC of InstrD
- PCPlus4D  input  32  PCD+4
- RegWriteW  input  1  writeback write enable
- RdW  input  5  writeback destination register
- ResultW  input  32  writeback data
- FlushE  input  1  insert bubble into E on next edge
- RegWriteE  output  1  register write enable to E
- ResultSrcE  output  1  0 = ALU result, 1 = memory data
- MemWriteE  output  1  store enable
- BranchE  output  1  beq in E
- ALUSrcE  output  1  0 = RD2, 1 = immediate
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E  output  32 each  rs1/rs2 operand values
- ImmExtE  output  32  sign-extended immediate
- Rs1E, Rs2E, RdE  output  5 each  register indices for the hazard unit
- PCE, PCPlus4E  output  32 each  registered PC values

Behaviour:
- **Register file write:** x1..x31 written on a rising edge when RegWriteW=1, RdW!=0 and rst_n=1. x0 always reads 0, and writes to it are discarded.
- **Register file read:** combinational on InstrD[19:15] and InstrD[24:20].
  - If RegWriteW=1, RdW!=0 and RdW equals the read index, ResultW is returned (same-cycle bypass, no write-then-read hazard).
- **Register file reset:** while rst_n=0 at an edge, x1..x31 clear to 0. Writes presented during reset are ignored.
- **Decode by opcode** (fields: RegWrite, ResultSrc, MemWrite, Branch, ALUSrc, imm type, ALU op):
  - 0000011 lw: 1,1,0,0,1, I-type, add.
  - 0100011 sw: 0,0,1,0,1, S-type, add.
  - 0110011 R-type: 1,0,0,0,0, imm=0, ALU op from funct3/funct7.
  - 0010011 I-ALU: 1,0,0,0,1, I-type, ALU op from funct3, never sub.
  - 1100011 beq: 0,0,0,1,0, B-type, sub.
  - Any other opcode: all controls 0, ALUControl 000, imm 0.
- **funct3 map:**
  - 000 = add; becomes sub only for R-type with funct7[5]=1.
  - 010 = slt.
  - 110 = or.
  - 111 = and.
  - Any other funct3 = add.
- **Immediates:**
  - I = sext(Instr[31:20]).
  - S = sext({Instr[31:25], Instr[11:7]}).
  - B = sext({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}).
- **ID/EX register:** updates on every rising edge, 1-cycle latency from D inputs to E outputs. There is no E stall input.
- **Reset and flush of ID/EX:** rst_n=0 or FlushE=1 at an edge sets every E output to 0 (controls, data, indices, PCs).
  - Reset has priority over FlushE.
  - A flush does not block a register-file write in the same cycle.
- **Output reset values:** all outputs are 0 after reset. Outputs are undefined only before the first reset edge.

Test Plan:
1. **Reset clears registers:** hold rst_n=0 for 2 cycles with RegWriteW=1, RdW=5, ResultW=0x0000DEAD; release; InstrD=0x005282B3 (add x5,x5,x5) -> next edge RD1E=RD2E=0, RdE=5, RegWriteE=1, ALUControlE=000.
2. **Write then read:** RegWriteW=1, RdW=3, ResultW=0x00001234 for one edge; then InstrD=0x00018233 (add x4,x3,x0) with RegWriteW=0 -> RD1E=0x00001234, RD2E=0, Rs1E=3, RdE=4.
3. **Same-cycle bypass:** InstrD=0x00018233 with RegWriteW=1, RdW=3, ResultW=0xCAFEF00D in the same cycle -> RD1E=0xCAFEF00D after the edge, and x3 holds 0xCAFEF00D on later reads.
4. **x0 protection:** RegWriteW=1, RdW=0, ResultW=0xFFFFFFFF, InstrD reading x0 as rs1 and rs2 -> RD1E=RD2E=0, both same-cycle and later.
5. **lw decode:** InstrD=0xFFC12303 (lw x6,-4(x2)) -> RegWriteE=1, ResultSrcE=1, ALUSrcE=1, MemWriteE=0, BranchE=0, ALUControlE=000, ImmExtE=0xFFFFFFFC, RdE=6, Rs1E=2.
6. **beq decode and flush:** InstrD=0x00208463 (beq x1,x2,+8)
   - FlushE=0 -> BranchE=1, ALUControlE=001, ALUSrcE=0, ImmExtE=0x00000008.
   - Repeat with FlushE=1 -> every E output 0.
   - FlushE=1 together with rst_n=0 -> all outputs 0.
